gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter SIZE, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port clr, input, 1 bit: synchronous clear to count zero.
REQ-005 SHALL have port load, input, 1 bit: synchronous load of load_bin.
REQ-006 SHALL have port load_bin, input, SIZE bits: load value in plain binary.
REQ-007 SHALL have port en, input, 1 bit: count enable.
REQ-008 SHALL have port up_dn, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-009 SHALL have port gray, output, SIZE bits: registered Gray-coded count, for direct connection to the Gray2Bin stage.
REQ-010 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a count wrap-around.

Function
REQ-011 SHALL hold an internal SIZE-bit binary count bin_q; gray SHALL be a register equal to bin_q ^ (bin_q >> 1) at all times after reset.
REQ-012 SHALL apply input priority per rising edge: clr > load > en; with none asserted, bin_q, gray hold and wrap = 0.
REQ-013 With clr = 1, SHALL set bin_q = 0, gray = 0, wrap = 0 on the next edge, regardless of load, en, up_dn.
REQ-014 With clr = 0 and load = 1, SHALL set bin_q = load_bin and gray = load_bin ^ (load_bin >> 1) on the next edge, with wrap = 0; en is ignored that cycle.
REQ-015 With clr = 0, load = 0, en = 1, up_dn = 1, SHALL set bin_q = bin_q + 1 modulo 2^SIZE.
REQ-016 With clr = 0, load = 0, en = 1, up_dn = 0, SHALL set bin_q = bin_q - 1 modulo 2^SIZE.
REQ-017 Latency: gray and wrap SHALL reflect the sampled control inputs exactly one clk edge later; there is no combinational path from any input to gray or wrap.
REQ-018 SHALL assert wrap for exactly one cycle, concurrently with the wrapped gray value, when an up-count takes bin_q from 2^SIZE-1 to 0.
REQ-019 SHALL assert wrap for exactly one cycle, concurrently with the wrapped gray value, when a down-count takes bin_q from 0 to 2^SIZE-1.
REQ-020 SHALL keep wrap = 0 on clear and load, including loads of 0 or 2^SIZE-1.
REQ-021 With en held at 1, SHALL re-evaluate wrap every cycle, so it is never held high longer than one cycle.
REQ-022 Every count step (REQ-015/016) SHALL change exactly one bit of gray, including at wrap-around.
REQ-023 A change of up_dn between consecutive enabled cycles SHALL take effect on the next edge with no idle cycle.

Reset
REQ-024 While rst_n = 0, SHALL force bin_q = 0, gray = 0 and wrap = 0 immediately, independent of clk.
REQ-025 SHALL release from reset synchronously: the first state change occurs on the first rising clk edge where rst_n = 1, following REQ-012.
REQ-026 Reset asserted mid-count SHALL discard the count; after release, counting resumes from 0.

Verification
REQ-027 Reset then up-count (SIZE = 4, en = 1, up_dn = 1) -> gray = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex); wrap = 1 only with the final 0; exactly one gray bit changes per step.
REQ-028 Reset then down-count, one enabled cycle (en = 1, up_dn = 0) -> gray = 8 (bin F) and wrap = 1 for one cycle; the next step gives gray = 9, wrap = 0.
REQ-029 load = 1, load_bin = 5 with en = 1 -> next cycle gray = 7 and wrap = 0; then up-count gives gray = 5 (bin 6).
REQ-030 clr = 1 with load = 1, load_bin = F and en = 1 in the same cycle -> gray = 0, wrap = 0.
REQ-031 Count to gray = D, drop en for 3 cycles -> gray holds D and wrap = 0; toggle up_dn mid-run -> direction reverses on the next edge.
REQ-032 Assert rst_n = 0 asynchronously between clk edges at gray = E -> gray = 0 and wrap = 0 before the next edge; after release, the first up-count gives gray = 1.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded output and a wrap pulse.
// Latency 1 clk from sampled controls to gray/wrap; no backpressure (en gates counting).
module gray_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  input  logic            en,
  input  logic            up_dn,
  output logic [SIZE-1:0] gray,
  output logic            wrap
);

  logic [SIZE-1:0] bin_q;
  logic [SIZE-1:0] bin_d;
  logic            wrap_d;

  // Priority clr > load > en; wrap only fires on a count step that crosses the end.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = ~|bin_q;
      end
    end
  end

  // gray is encoded from the next binary value so it lands in the same cycle as bin_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      gray  <= '0;
      wrap  <= 1'b0;
    end else begin
      bin_q <= bin_d;
      gray  <= bin_d ^ (bin_d >> 1);
      wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (SIZE = 4): scoreboard of expected gray/wrap per cycle.
module tb_gray_counter;

  localparam int SIZE = 4;

  logic            clk;
  logic            rst_n;
  logic            clr;
  logic            load;
  logic [SIZE-1:0] load_bin;
  logic            en;
  logic            up_dn;
  logic [SIZE-1:0] gray;
  logic            wrap;

  typedef struct packed {
    logic [SIZE-1:0] gray;
    logic            wrap;
  } exp_t;

  exp_t            sb[$];
  logic [SIZE-1:0] mbin;
  int              n_checks;
  int              n_fail;

  gray_counter #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_bin (load_bin),
    .en       (en),
    .up_dn    (up_dn),
    .gray     (gray),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of controls, push the model's expectation, and wait until
  // just after the edge that samples them.
  task automatic drive(input logic c, input logic l, input logic [SIZE-1:0] lb,
                       input logic e, input logic u);
    exp_t            x;
    logic [SIZE-1:0] nb;
    logic            w;
    clr = c; load = l; load_bin = lb; en = e; up_dn = u;
    w  = 1'b0;
    nb = mbin;
    if (c) nb = 0;
    else if (l) nb = lb;
    else if (e && u) begin
      w  = (mbin == {SIZE{1'b1}});
      nb = mbin + 1;
    end else if (e) begin
      w  = (mbin == 0);
      nb = mbin - 1;
    end
    mbin   = nb;
    x.gray = nb ^ (nb >> 1);
    x.wrap = w;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 0; load = 0; load_bin = 0; en = 0; up_dn = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mbin  = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 0; load = 0; load_bin = 0; en = 1; up_dn = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (gray !== 4'h0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got gray=%h wrap=%b, expected gray=0 wrap=0", gray, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mbin  = 0;
    sb.delete();
  endtask

  task automatic test_up_count();
    logic [SIZE-1:0] gtab [16];
    logic [SIZE-1:0] prev;
    exp_t            e;
    gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    do_reset();
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 1);
      e = sb.pop_front();
      n_checks++;
      if (gray !== e.gray || gray !== gtab[i]) begin
        n_fail++;
        $display("FAIL up_gray[%0d]: got %h expected %h", i, gray, gtab[i]);
      end
      n_checks++;
      if (wrap !== e.wrap || wrap !== (i == 15)) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, (i == 15));
      end
      n_checks++;
      if ($countones(gray ^ prev) != 1) begin
        n_fail++;
        $display("FAIL up_onebit[%0d]: got %h after %h, expected one bit change", i, gray, prev);
      end
      prev = gray;
    end
    drive(0, 0, 0, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== e.wrap) begin
      n_fail++;
      $display("FAIL up_after_wrap: got gray=%h wrap=%b expected gray=%h wrap=%b",
               gray, wrap, e.gray, e.wrap);
    end
  endtask

  task automatic test_down_count();
    exp_t e;
    do_reset();
    drive(0, 0, 0, 1, 0);
    e = sb.pop_front();
    n_checks++;
    if (gray !== 4'h8 || wrap !== 1'b1 || e.gray !== 4'h8 || e.wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: got gray=%h wrap=%b expected gray=8 wrap=1", gray, wrap);
    end
    drive(0, 0, 0, 1, 0);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== e.wrap || gray !== 4'h9) begin
      n_fail++;
      $display("FAIL down_step: got gray=%h wrap=%b expected gray=9 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_load();
    exp_t e;
    drive(0, 1, 4'h5, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== e.wrap || gray !== 4'h7) begin
      n_fail++;
      $display("FAIL load5: got gray=%h wrap=%b expected gray=7 wrap=0", gray, wrap);
    end
    drive(0, 0, 0, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== e.wrap || gray !== 4'h5) begin
      n_fail++;
      $display("FAIL load_then_up: got gray=%h wrap=%b expected gray=5 wrap=0", gray, wrap);
    end
    drive(0, 1, 4'hF, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== 1'b0 || gray !== 4'h8) begin
      n_fail++;
      $display("FAIL loadF: got gray=%h wrap=%b expected gray=8 wrap=0", gray, wrap);
    end
    drive(0, 1, 4'h0, 1, 0);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== 1'b0 || gray !== 4'h0) begin
      n_fail++;
      $display("FAIL load0: got gray=%h wrap=%b expected gray=0 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_clr_priority();
    exp_t e;
    drive(0, 1, 4'h6, 0, 1);
    e = sb.pop_front();
    drive(1, 1, 4'hF, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== e.wrap || gray !== 4'h0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_over_load: got gray=%h wrap=%b expected gray=0 wrap=0", gray, wrap);
    end
    drive(0, 1, 4'hF, 0, 1);
    e = sb.pop_front();
    drive(1, 0, 4'h0, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== 4'h0 || wrap !== 1'b0 || e.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_at_max: got gray=%h wrap=%b expected gray=0 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_hold_and_reverse();
    exp_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 1, 1);
      e = sb.pop_front();
    end
    n_checks++;
    if (gray !== 4'hD) begin
      n_fail++;
      $display("FAIL reach_D: got gray=%h expected gray=D", gray);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, i[0]);
      e = sb.pop_front();
      n_checks++;
      if (gray !== e.gray || wrap !== e.wrap || gray !== 4'hD || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got gray=%h wrap=%b expected gray=D wrap=0", i, gray, wrap);
      end
    end
    drive(0, 0, 0, 1, 0);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || gray !== 4'hC) begin
      n_fail++;
      $display("FAIL reverse_down: got gray=%h expected gray=C", gray);
    end
    drive(0, 0, 0, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || gray !== 4'hD) begin
      n_fail++;
      $display("FAIL reverse_up: got gray=%h expected gray=D", gray);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      e = sb.pop_front();
      n_checks++;
      if (gray !== e.gray || wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL random[%0d]: got gray=%h wrap=%b expected gray=%h wrap=%b",
                 i, gray, wrap, e.gray, e.wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 1, 1);
      e = sb.pop_front();
    end
    n_checks++;
    if (gray !== 4'hE) begin
      n_fail++;
      $display("FAIL reach_E: got gray=%h expected gray=E", gray);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gray !== 4'h0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got gray=%h wrap=%b expected gray=0 wrap=0", gray, wrap);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mbin  = 0;
    sb.delete();
    drive(0, 0, 0, 1, 1);
    e = sb.pop_front();
    n_checks++;
    if (gray !== e.gray || wrap !== e.wrap || gray !== 4'h1) begin
      n_fail++;
      $display("FAIL after_reset_up: got gray=%h wrap=%b expected gray=1 wrap=0", gray, wrap);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mbin     = 0;
    rst_n    = 1'b0;
    clr = 0; load = 0; load_bin = 0; en = 0; up_dn = 1;
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_clr_priority();
    test_hold_and_reverse();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
